csa_accum_sequencer: RTL and testbench



---
 rtl/csa_accum_sequencer_if.sv | 23 ++
 rtl/csa_accum_sequencer.sv | 158 +++++++++++++++
 tb/tb_csa_accum_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_sequencer_if.sv
// Operand-stream / result handshake bundle for csa_accum_sequencer.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface csa_accum_sequencer_if #(
    parameter int XLEN = 49
);
    logic            op_valid_i;
    logic            op_ready_o;
    logic [XLEN-1:0] op_data_i;
    logic            op_last_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [XLEN-1:0] res_data_o;

    modport slave (
        input  op_valid_i, op_data_i, op_last_i, res_ready_i,
        output op_ready_o, res_valid_o, res_data_o
    );

    modport master (
        output op_valid_i, op_data_i, op_last_i, res_ready_i,
        input  op_ready_o, res_valid_o, res_data_o
    );
endinterface

// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: folds one operand per cycle into redundant sum/carry
// registers through a single 3:2 compressor, then resolves the group with one
// carry-propagate add and presents it on a valid/ready result port.
// Optional feature macro: CSA_SEQ_OVF_EN adds a sticky unsigned-overflow flag ovf_o.
module csa_accum_sequencer #(
    parameter int XLEN  = 49,
    parameter int CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    csa_accum_sequencer_if.slave bus,
    output logic [CNT_W-1:0]     op_count_o,
`ifdef CSA_SEQ_OVF_EN
    output logic                 ovf_o,
`endif
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   sum_r;
    logic [XLEN-1:0]   carry_r;
    logic              ready_r;
    logic              res_valid_r;
    logic [XLEN-1:0]   res_data_r;
    logic [CNT_W-1:0]  count_r;
    logic              busy_r;

    logic              accept;
    logic [XLEN-1:0]   csa_a;
    logic [XLEN-1:0]   csa_b;
    logic [XLEN-1:0]   csa_sum;
    logic [XLEN-1:0]   csa_carry;

`ifdef CSA_SEQ_OVF_EN
    logic              ovf_r;
    logic [XLEN:0]     resolve_sum;
    assign resolve_sum = {1'b0, sum_r} + {1'b0, carry_r};
    assign ovf_o       = ovf_r;
`else
    logic [XLEN-1:0]   resolve_sum;
    assign resolve_sum = sum_r + carry_r;
`endif

    assign accept          = bus.op_valid_i & ready_r;
    assign bus.op_ready_o  = ready_r;
    assign bus.res_valid_o = res_valid_r;
    assign bus.res_data_o  = res_data_r;
    assign op_count_o      = count_r;
    assign busy_o          = busy_r;

    // Shared 3:2 compressor; a new group starts from zero so IDLE forces A=B=0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        csa_a = sum_r;
        csa_b = carry_r;
        if (state == IDLE) begin
            csa_a = '0;
            csa_b = '0;
        end
        csa_sum   = csa_a ^ csa_b ^ bus.op_data_i;
        csa_carry = (csa_a & csa_b) | (csa_a & bus.op_data_i) | (csa_b & bus.op_data_i);
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        // NOTE: state is written with <= only, so every register samples pre-edge values.
        if (rst_i) begin
            state       <= IDLE;
            sum_r       <= '0;
            carry_r     <= '0;
            ready_r     <= 1'b1;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            count_r     <= '0;
            busy_r      <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else if (flush_i) begin
            // Abort wins over any operand or result handshake in the same cycle.
            state       <= IDLE;
            sum_r       <= '0;
            carry_r     <= '0;
            ready_r     <= 1'b1;
            res_valid_r <= 1'b0;
            count_r     <= '0;
            busy_r      <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        // carry_r is kept pre-shifted so sum_r + carry_r is the running total.
                        sum_r   <= csa_sum;
                        carry_r <= csa_carry << 1;
                        busy_r  <= 1'b1;
                        if (state == IDLE) begin
                            count_r <= CNT_W'(1);
`ifdef CSA_SEQ_OVF_EN
                            ovf_r   <= csa_carry[XLEN-1];
`endif
                        end else begin
                            if (count_r != {CNT_W{1'b1}}) begin
                                count_r <= count_r + CNT_W'(1);
                            end
`ifdef CSA_SEQ_OVF_EN
                            ovf_r   <= ovf_r | csa_carry[XLEN-1];
`endif
                        end
                        if (bus.op_last_i) begin
                            state   <= RESOLVE;
                            ready_r <= 1'b0;
                        end else begin
                            state   <= ACCUM;
                        end
                    end
                end
                RESOLVE: begin
                    res_data_r  <= resolve_sum[XLEN-1:0];
                    res_valid_r <= 1'b1;
                    state       <= DONE;
`ifdef CSA_SEQ_OVF_EN
                    ovf_r       <= ovf_r | resolve_sum[XLEN];
`endif
                end
                DONE: begin
                    if (bus.res_ready_i) begin
                        res_valid_r <= 1'b0;
                        sum_r       <= '0;
                        carry_r     <= '0;
                        ready_r     <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
`ifdef CSA_SEQ_OVF_EN
                        ovf_r       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Self-checking bench for csa_accum_sequencer: directed scenarios plus random
// groups, compared against an arithmetic model (plain wide sum of the group).
module tb_csa_accum_sequencer;

    localparam int XLEN  = 49;
    localparam int CNT_W = 8;
    typedef logic [XLEN-1:0] word_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic [CNT_W-1:0] op_count_o;
    logic             busy_o;
`ifdef CSA_SEQ_OVF_EN
    logic             ovf_o;
`endif

    csa_accum_sequencer_if #(.XLEN(XLEN)) bus ();

    csa_accum_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .bus        (bus.slave),
        .op_count_o (op_count_o),
`ifdef CSA_SEQ_OVF_EN
        .ovf_o      (ovf_o),
`endif
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int    checks = 0;
    int    errors = 0;
    word_t grp[$];

    // Reference: exact sum of the group in 64 bits, then reduce.
    function automatic logic [63:0] model_total();
        logic [63:0] t = 64'd0;
        foreach (grp[i]) t = t + 64'(grp[i]);
        return t;
    endfunction

    function automatic word_t model_sum();
        logic [63:0] t = model_total();
        return t[XLEN-1:0];
    endfunction

    function automatic logic model_ovf();
        logic [63:0] t = model_total();
        return |t[63:XLEN];
    endfunction

    function automatic logic [CNT_W-1:0] model_count();
        int n = grp.size();
        if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
        return CNT_W'(n);
    endfunction

    function automatic word_t rand_word();
        return {$urandom, $urandom};
    endfunction

    // Present one operand from a negedge and return at the negedge after it is accepted.
    task automatic send_op(input word_t d, input logic last);
        int n = 0;
        bus.op_valid_i = 1'b1;
        bus.op_data_i  = d;
        bus.op_last_i  = last;
        while (bus.op_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n == 50) begin
            errors++;
            $display("FAIL send_op_timeout: op_ready_o=%b after 50 cycles, required 1", bus.op_ready_o);
        end
        @(negedge clk_i);
        bus.op_valid_i = 1'b0;
        bus.op_last_i  = $urandom_range(1);
        bus.op_data_i  = rand_word();
    endtask

    task automatic bubble(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            bus.op_valid_i = 1'b0;
            bus.op_last_i  = $urandom_range(1);
            bus.op_data_i  = rand_word();
            @(negedge clk_i);
        end
    endtask

    // Stream the whole of grp; gap fixed bubbles plus random bubbles before each later operand.
    task automatic drive_group(input int gap, input int bubble_pct);
        for (int i = 0; i < grp.size(); i++) begin
            if (i > 0) begin
                bubble(gap);
                while ($urandom_range(99) < bubble_pct) bubble(1);
            end
            send_op(grp[i], i == grp.size() - 1);
        end
    endtask

    // Called at the negedge right after the last accept; checks latency, holds, and the handshake.
    task automatic check_result(input string name, input int stall);
        word_t exp_data = model_sum();
        logic [CNT_W-1:0] exp_cnt = model_count();
        checks++;
        if (bus.res_valid_o !== 1'b0 || bus.op_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_resolve: valid=%b ready=%b busy=%b, required 0 0 1",
                     name, bus.res_valid_o, bus.op_ready_o, busy_o);
        end
        bus.res_ready_i = 1'b0;
        @(negedge clk_i);
        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== exp_data || bus.op_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_result[%0d]: valid=%b data=%h ready=%b, required 1 %h 0",
                         name, s, bus.res_valid_o, bus.res_data_o, bus.op_ready_o, exp_data);
            end
            checks++;
            if (op_count_o !== exp_cnt) begin
                errors++;
                $display("FAIL %s_count: got %0d, required %0d", name, op_count_o, exp_cnt);
            end
`ifdef CSA_SEQ_OVF_EN
            checks++;
            if (ovf_o !== model_ovf()) begin
                errors++;
                $display("FAIL %s_ovf: got %b, required %b", name, ovf_o, model_ovf());
            end
`endif
            if (s < stall) @(negedge clk_i);
        end
        bus.res_ready_i = 1'b1;
        @(negedge clk_i);
        bus.res_ready_i = 1'b0;
        checks++;
        if (bus.res_valid_o !== 1'b0 || bus.op_ready_o !== 1'b1 || busy_o !== 1'b0 || op_count_o !== exp_cnt) begin
            errors++;
            $display("FAIL %s_release: valid=%b ready=%b busy=%b count=%0d, required 0 1 0 %0d",
                     name, bus.res_valid_o, bus.op_ready_o, busy_o, op_count_o, exp_cnt);
        end
`ifdef CSA_SEQ_OVF_EN
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovf_clear: got %b, required 0", name, ovf_o);
        end
`endif
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (bus.res_valid_o !== 1'b0 || bus.op_ready_o !== 1'b1 || busy_o !== 1'b0 || op_count_o !== '0) begin
            errors++;
            $display("FAIL %s: valid=%b ready=%b busy=%b count=%0d, required 0 1 0 0",
                     name, bus.res_valid_o, bus.op_ready_o, busy_o, op_count_o);
        end
`ifdef CSA_SEQ_OVF_EN
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovf: got %b, required 0", name, ovf_o);
        end
`endif
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        flush_i = 1'b1;
        bus.op_valid_i = 1'b1;
        bus.op_data_i  = rand_word();
        bus.op_last_i  = 1'b1;
        bus.res_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        flush_i = 1'b0;
        bus.op_valid_i = 1'b0;
        bus.op_last_i  = 1'b0;
        check_idle("reset_state");
        checks++;
        if (bus.res_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0", bus.res_data_o);
        end
    endtask

    task automatic test_basic();
        grp = '{word_t'(3), word_t'(5), word_t'(7)};
        drive_group(0, 0);
        check_result("basic", 0);
    endtask

    task automatic test_single();
        grp = '{word_t'(49'h1_2345_6789)};
        drive_group(0, 0);
        check_result("single", 1);
    endtask

    task automatic test_bubble_backpressure();
        grp = '{word_t'(10), word_t'(20)};
        drive_group(3, 0);
        check_result("bubble", 4);
    endtask

    task automatic test_flush();
        send_op(word_t'(100), 1'b0);
        send_op(word_t'(200), 1'b0);
        bus.op_valid_i = 1'b1;
        bus.op_data_i  = word_t'(50);
        bus.op_last_i  = 1'b1;
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        bus.op_valid_i = 1'b0;
        bus.op_last_i  = 1'b0;
        check_idle("flush_accum");
        bubble(3);
        check_idle("flush_no_result");
        grp = '{word_t'(1), word_t'(2)};
        drive_group(0, 0);
        check_result("after_flush", 0);
        // Flush while a result is pending in DONE drops it even with res_ready_i high.
        send_op(word_t'(7), 1'b1);
        @(negedge clk_i);
        bus.res_ready_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        bus.res_ready_i = 1'b0;
        check_idle("flush_done");
    endtask

    task automatic test_back_to_back();
        grp = '{word_t'(4), word_t'(4)};
        drive_group(0, 0);
        check_result("b2b_first", 0);
        grp = '{word_t'(9)};
        drive_group(0, 0);
        check_result("b2b_second", 0);
    endtask

    task automatic test_saturation();
        grp.delete();
        for (int i = 0; i < 300; i++) grp.push_back(rand_word());
        drive_group(0, 0);
        check_result("saturate", 0);
    endtask

    task automatic test_random();
        for (int g = 0; g < 40; g++) begin
            int n = $urandom_range(1, 12);
            grp.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3))
                    0:       grp.push_back(word_t'($urandom_range(255)));
                    1:       grp.push_back({1'b1, 48'(rand_word())});
                    default: grp.push_back(rand_word());
                endcase
            end
            drive_group(0, 30);
            check_result($sformatf("rand%0d", g), $urandom_range(0, 3));
        end
    endtask

`ifdef CSA_SEQ_OVF_EN
    task automatic test_overflow();
        grp = '{word_t'(49'h1_0000_0000_0000), word_t'(49'h1_0000_0000_0000)};
        drive_group(0, 0);
        check_result("ovf_wrap", 0);
        grp = '{word_t'(1)};
        drive_group(0, 0);
        check_result("ovf_next", 0);
    endtask
`endif

    initial begin
        bus.op_valid_i  = 1'b0;
        bus.op_data_i   = '0;
        bus.op_last_i   = 1'b0;
        bus.res_ready_i = 1'b0;
        flush_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_single();
        test_bubble_backpressure();
        test_flush();
        test_back_to_back();
        test_saturation();
`ifdef CSA_SEQ_OVF_EN
        test_overflow();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
